// File: rtl/basket_pkg.sv
// -----------------------------------------------------------------------------
// basket_pkg
// Shared types and constants for the shopping-basket controller.
//   ID_W / QTY_W  : widths of product identifiers and quantities
//   CNT_W         : width of entry counts and entry indices
//   QTY_MAX       : saturation ceiling for a merged quantity
//   DEPTH         : physical storage slots (every 4-bit index is addressable)
//   state_t       : controller FSM encoding
//   entry_t       : one basket record {product_id, quantity}
// -----------------------------------------------------------------------------
package basket_pkg;

  localparam int ID_W  = 4;
  localparam int QTY_W = 4;
  localparam int CNT_W = 4;
  localparam int DEPTH = 1 << CNT_W;

  localparam logic [QTY_W-1:0] QTY_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_WRITE  = 2'd2,
    ST_SHIFT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]  product_id;
    logic [QTY_W-1:0] quantity;
  } entry_t;

endpackage

// File: rtl/basket_controller.sv
// -----------------------------------------------------------------------------
// basket_controller
// Holds up to MAX_ENTRIES (1..15) {product, quantity} records. An add either
// merges into an existing record with the same product (saturating quantity)
// or appends a new one; a cancel removes one record by index and closes the
// gap by shifting the tail down one slot per cycle.
//
// Optional feature macro: BASKET_MERGE_EN
//   defined   : adds scan the basket one entry per cycle and merge repeats
//   undefined : adds always append (or are rejected when full), 1-cycle latency
//
// Ports
//   CLOCK_50          in   system clock, all state on its rising edge
//   RESET             in   synchronous active-high reset
//   Enable_Pulse      in   one-cycle add command
//   Cancel_Pulse      in   one-cycle remove command (cancel wins over add)
//   ProductID[3:0]    in   product to add / entry index to cancel
//   ProductQuantity   in   quantity to add; zero makes the add a no-op
//   Read_Index[3:0]   in   entry to display
//   BasketProductNum  out  number of valid entries
//   Read_ProductID    out  registered product of entry Read_Index (0 if invalid)
//   Read_Quantity     out  registered quantity of entry Read_Index (0 if invalid)
//   Busy              out  high while a command is being executed
//   Update_Pulse      out  one cycle, command completed and basket changed
//   Error_Pulse       out  one cycle, command rejected
// -----------------------------------------------------------------------------
module basket_controller
  import basket_pkg::*;
#(
  parameter int MAX_ENTRIES = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             Enable_Pulse,
  input  logic             Cancel_Pulse,
  input  logic [ID_W-1:0]  ProductID,
  input  logic [QTY_W-1:0] ProductQuantity,
  input  logic [CNT_W-1:0] Read_Index,
  output logic [CNT_W-1:0] BasketProductNum,
  output logic [ID_W-1:0]  Read_ProductID,
  output logic [QTY_W-1:0] Read_Quantity,
  output logic             Busy,
  output logic             Update_Pulse,
  output logic             Error_Pulse
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_ENTRIES);

  state_t           state_q;
  entry_t           entries_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] idx_q;    // scan position, merge target or shift position
  logic             hit_q;    // SEARCH found the captured product at idx_q
  entry_t           cap_q;    // captured add request
  entry_t           rd_q;
  logic             busy_q;
  logic             upd_q;
  logic             err_q;

  function automatic logic [QTY_W-1:0] sat_add(input logic [QTY_W-1:0] a,
                                               input logic [QTY_W-1:0] b);
    logic [QTY_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, QTY_MAX}) ? QTY_MAX : sum[QTY_W-1:0];
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      cap_q   <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      rd_q  <= (Read_Index < count_q) ? entries_q[Read_Index] : '0;

      // A command arriving mid-operation is rejected but never touches it.
      if (state_q != ST_IDLE && (Enable_Pulse || Cancel_Pulse)) err_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (Cancel_Pulse) begin
            // Cancel has priority; a coincident add is dropped silently.
            if (ProductID < count_q) begin
              idx_q   <= ProductID;
              busy_q  <= 1'b1;
              state_q <= ST_SHIFT;
            end else begin
              err_q <= 1'b1;
            end
          end else if (Enable_Pulse && ProductQuantity != '0) begin
            cap_q  <= '{product_id: ProductID, quantity: ProductQuantity};
            idx_q  <= '0;
            hit_q  <= 1'b0;
            busy_q <= 1'b1;
`ifdef BASKET_MERGE_EN
            state_q <= (count_q == '0) ? ST_WRITE : ST_SEARCH;
`else
            state_q <= ST_WRITE;
`endif
          end
        end

        ST_SEARCH: begin
          // idx_q is left pointing at the matching entry for WRITE.
          if (entries_q[idx_q].product_id == cap_q.product_id) begin
            hit_q   <= 1'b1;
            state_q <= ST_WRITE;
          end else if (idx_q == count_q - 4'd1) begin
            state_q <= ST_WRITE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end

        ST_WRITE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (hit_q) begin
            entries_q[idx_q].quantity <= sat_add(entries_q[idx_q].quantity,
                                                 cap_q.quantity);
            upd_q <= 1'b1;
          end else if (count_q < CAP) begin
            entries_q[count_q] <= cap_q;
            count_q            <= count_q + 4'd1;
            upd_q              <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end

        ST_SHIFT: begin
          // Close the gap one slot per cycle, then drop the stale tail copy.
          if (idx_q == count_q - 4'd1) begin
            entries_q[idx_q] <= '0;
            count_q          <= count_q - 4'd1;
            upd_q            <= 1'b1;
            busy_q           <= 1'b0;
            state_q          <= ST_IDLE;
          end else begin
            entries_q[idx_q] <= entries_q[idx_q + 4'd1];
            idx_q            <= idx_q + 4'd1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BasketProductNum = count_q;
  assign Read_ProductID   = rd_q.product_id;
  assign Read_Quantity    = rd_q.quantity;
  assign Busy             = busy_q;
  assign Update_Pulse     = upd_q;
  assign Error_Pulse      = err_q;

endmodule

// File: tb/tb_basket_controller.sv
// -----------------------------------------------------------------------------
// tb_basket_controller
// Directed bench for basket_controller. Each command pushes its expected
// completion event (update or error, resulting entry count, arrival cycle)
// into a scoreboard queue; a monitor on the falling edge pops and compares
// whenever the DUT raises Update_Pulse or Error_Pulse. Register contents are
// checked through the read port. Build with BASKET_MERGE_EN to cover merging.
// -----------------------------------------------------------------------------
module tb_basket_controller;

  logic       CLOCK_50 = 1'b0;
  logic       RESET = 1'b1;
  logic       Enable_Pulse = 1'b0;
  logic       Cancel_Pulse = 1'b0;
  logic [3:0] ProductID = '0;
  logic [3:0] ProductQuantity = '0;
  logic [3:0] Read_Index = '0;
  logic [3:0] BasketProductNum;
  logic [3:0] Read_ProductID;
  logic [3:0] Read_Quantity;
  logic       Busy;
  logic       Update_Pulse;
  logic       Error_Pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

`ifdef BASKET_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  typedef struct {
    bit    is_err;
    int    cnt;
    int    at;
    string name;
  } exp_t;

  exp_t sb[$];

  basket_controller #(.MAX_ENTRIES(8)) dut (
    .CLOCK_50         (CLOCK_50),
    .RESET            (RESET),
    .Enable_Pulse     (Enable_Pulse),
    .Cancel_Pulse     (Cancel_Pulse),
    .ProductID        (ProductID),
    .ProductQuantity  (ProductQuantity),
    .Read_Index       (Read_Index),
    .BasketProductNum (BasketProductNum),
    .Read_ProductID   (Read_ProductID),
    .Read_Quantity    (Read_Quantity),
    .Busy             (Busy),
    .Update_Pulse     (Update_Pulse),
    .Error_Pulse      (Error_Pulse)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (mon_en && (Update_Pulse === 1'b1 || Error_Pulse === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event upd=%0b err=%0b cnt=%0d cyc=%0d required=none",
                 Update_Pulse, Error_Pulse, BasketProductNum, cyc);
      end else begin
        e = sb.pop_front();
        if (Update_Pulse !== !e.is_err || Error_Pulse !== e.is_err ||
            BasketProductNum !== 4'(e.cnt) || cyc != e.at) begin
          errors++;
          $display("FAIL %s actual upd=%0b err=%0b cnt=%0d cyc=%0d required upd=%0b err=%0b cnt=%0d cyc=%0d",
                   e.name, Update_Pulse, Error_Pulse, BasketProductNum, cyc,
                   !e.is_err, e.is_err, e.cnt, e.at);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void expect_ev(bit is_err, int cnt, int at, string name);
    exp_t e;
    e.is_err = is_err;
    e.cnt    = cnt;
    e.at     = at;
    e.name   = name;
    sb.push_back(e);
  endfunction

  task automatic pulse(bit en, bit cn, int id, int q);
    Enable_Pulse    = en;
    Cancel_Pulse    = cn;
    ProductID       = 4'(id);
    ProductQuantity = 4'(q);
    tick();
    Enable_Pulse = 1'b0;
    Cancel_Pulse = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic rd(int idx, int exp_id, int exp_q);
    Read_Index = 4'(idx);
    tick();
    chk($sformatf("read_id[%0d]", idx), int'(Read_ProductID), exp_id);
    chk($sformatf("read_qty[%0d]", idx), int'(Read_Quantity), exp_q);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
  endtask

  initial begin
    int p;
    RESET = 1'b1;
    Read_Index = 4'd0;
    tick();
    tick();
    chk("rst_count", int'(BasketProductNum), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_update", int'(Update_Pulse), 0);
    chk("rst_error", int'(Error_Pulse), 0);
    chk("rst_read_id", int'(Read_ProductID), 0);
    chk("rst_read_qty", int'(Read_Quantity), 0);
    RESET = 1'b0;
    mon_en = 1'b1;
    tick();

    // First add into an empty basket.
    p = cyc + 1;
    expect_ev(0, 1, p + 1, "add_first");
    pulse(1, 0, 3, 2);
    chk("busy_during_add", int'(Busy), 1);
    wait_done("add_first");
    rd(0, 3, 2);

    // Repeat product: merge with saturation, or a second entry.
    p = cyc + 1;
`ifdef BASKET_MERGE_EN
    expect_ev(0, 1, p + 2, "add_merge_sat");
`else
    expect_ev(0, 2, p + 1, "add_dup_append");
`endif
    pulse(1, 0, 3, 14);
    wait_done("add_repeat");
`ifdef BASKET_MERGE_EN
    rd(0, 3, 15);
`else
    rd(0, 3, 2);
    rd(1, 3, 14);
`endif

    // Fill to capacity, then overflow.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      p = cyc + 1;
      expect_ev(0, i, p + (MERGE ? i : 1), $sformatf("fill_%0d", i));
      pulse(1, 0, i, 1);
      wait_done("fill");
    end
    p = cyc + 1;
    expect_ev(1, 8, p + (MERGE ? 9 : 1), "add_full");
    pulse(1, 0, 9, 1);
    wait_done("add_full");
    chk("full_count", int'(BasketProductNum), 8);
    rd(0, 1, 1);
    rd(7, 8, 1);
    rd(8, 0, 0);

    // Basket {1,2,3,4}; cancel index 1, then an out-of-range cancel.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      p = cyc + 1;
      expect_ev(0, i, p + (MERGE ? i : 1), $sformatf("build_%0d", i));
      pulse(1, 0, i, i + 1);
      wait_done("build");
    end
    p = cyc + 1;
    expect_ev(0, 3, p + 3, "cancel_idx1");
    pulse(0, 1, 1, 0);
    wait_done("cancel_idx1");
    rd(0, 1, 2);
    rd(1, 3, 4);
    rd(2, 4, 5);
    rd(3, 0, 0);
    p = cyc + 1;
    expect_ev(1, 3, p, "cancel_oob");
    pulse(0, 1, 5, 0);
    wait_done("cancel_oob");
    chk("oob_count", int'(BasketProductNum), 3);

    // Add and cancel together: only the cancel of index 0 runs.
    p = cyc + 1;
    expect_ev(0, 2, p + 3, "en_cn_same");
    pulse(1, 1, 0, 5);
    wait_done("en_cn_same");
    rd(0, 3, 4);
    rd(1, 4, 5);
    rd(2, 0, 0);

    // New product; with merging a second add lands during SEARCH.
    p = cyc + 1;
`ifdef BASKET_MERGE_EN
    expect_ev(1, 2, p + 1, "en_in_search");
    expect_ev(0, 3, p + 3, "add_after_busy");
    pulse(1, 0, 6, 1);
    pulse(1, 0, 7, 2);
`else
    expect_ev(0, 3, p + 1, "add_six");
    pulse(1, 0, 6, 1);
`endif
    wait_done("add_six");
    chk("count_after_six", int'(BasketProductNum), 3);
    rd(2, 6, 1);
    rd(3, 0, 0);

    // Commands arriving during SHIFT are rejected; shift completes.
    p = cyc + 1;
    expect_ev(1, 3, p + 1, "en_in_shift");
    expect_ev(1, 3, p + 2, "cn_in_shift");
    expect_ev(0, 2, p + 3, "cancel_head");
    pulse(0, 1, 0, 0);
    pulse(1, 0, 9, 3);
    pulse(0, 1, 1, 0);
    wait_done("busy_shift");
    rd(0, 4, 5);
    rd(1, 6, 1);
    rd(2, 0, 0);

    // Zero-quantity add is ignored without a pulse.
    pulse(1, 0, 5, 0);
    tick();
    tick();
    chk("zero_qty_count", int'(BasketProductNum), 2);
    chk("zero_qty_busy", int'(Busy), 0);

    // Reset in the middle of SHIFT aborts silently.
    pulse(0, 1, 0, 0);
    chk("busy_in_shift", int'(Busy), 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mid_shift_rst_count", int'(BasketProductNum), 0);
    chk("mid_shift_rst_busy", int'(Busy), 0);
    tick();
    tick();
    tick();
    rd(0, 0, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/basket_controller.md
BASKET_CONTROLLER -- requirements
Module: basket_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLOCK_50 and RESET, both 1-bit inputs; all state SHALL update on the rising edge of CLOCK_50.
REQ-002 Parameter MAX_ENTRIES, default 8, SHALL set the basket capacity in entries (legal range 1..15).
REQ-003 CLOCK_50  input  1  system clock.
REQ-004 RESET  input  1  synchronous active-high reset.
REQ-005 Enable_Pulse  input  1  one-cycle add command.
REQ-006 Cancel_Pulse  input  1  one-cycle remove command.
REQ-007 ProductID  input  4  product to add; on cancel, the 0-based basket entry index.
REQ-008 ProductQuantity  input  4  quantity to add (1..15).
REQ-009 Read_Index  input  4  entry to display.
REQ-010 BasketProductNum  output  4  number of valid entries.
REQ-011 Read_ProductID / Read_Quantity  output  4 / 4  registered contents of entry Read_Index.
REQ-012 Busy  output  1  command in progress.
REQ-013 Update_Pulse  output  1  one cycle; command completed with a change.
REQ-014 Error_Pulse  output  1  one cycle; command rejected.

Function
REQ-015 The FSM SHALL have four states: IDLE, SEARCH, WRITE and SHIFT; Busy SHALL be high in every state except IDLE.
REQ-016 In IDLE, Enable_Pulse with ProductQuantity=0 SHALL be ignored, with no pulse.
REQ-017 In IDLE, Enable_Pulse with ProductQuantity!=0 SHALL capture ProductID and ProductQuantity and enter SEARCH.
REQ-018 SEARCH SHALL compare one entry per cycle, from index 0 up to BasketProductNum-1.
REQ-019 On a match, or when the scan is exhausted, SEARCH SHALL go to WRITE; with BasketProductNum=0 it SHALL go straight to WRITE.
REQ-020 WRITE on a match SHALL add the captured quantity to that entry, saturating at 15.
REQ-021 WRITE with no match and BasketProductNum<MAX_ENTRIES SHALL append at index BasketProductNum and increment the count.
REQ-022 WRITE with no match and a full basket SHALL leave the basket unchanged and assert Error_Pulse.
REQ-023 WRITE SHALL return to IDLE and assert Update_Pulse when the basket changed.
REQ-024 In IDLE, Cancel_Pulse with ProductID<BasketProductNum SHALL enter SHIFT.
REQ-025 In IDLE, Cancel_Pulse with ProductID>=BasketProductNum SHALL assert Error_Pulse and stay in IDLE.
REQ-026 SHIFT SHALL copy entry i+1 into entry i, one entry per cycle, from the cancelled index up to count-2.
REQ-027 SHIFT SHALL then clear the last entry, decrement the count, assert Update_Pulse and return to IDLE.
REQ-028 Simultaneous Enable_Pulse and Cancel_Pulse in IDLE: cancel SHALL win and the add SHALL be discarded silently.
REQ-029 Any command pulse arriving while Busy SHALL be dropped, assert Error_Pulse, and not disturb the operation in progress.
REQ-030 Worst-case add latency SHALL be BasketProductNum+1 cycles from pulse to Update_Pulse.
REQ-031 Worst-case cancel latency SHALL be count-index cycles.
REQ-032 Read_ProductID/Read_Quantity SHALL reflect Read_Index with one cycle of latency.
REQ-033 Read_Index>=BasketProductNum SHALL give zero on both read outputs.

Reset
REQ-034 RESET SHALL force IDLE, clear all entries, and drive BasketProductNum, Busy, Update_Pulse, Error_Pulse, Read_ProductID and Read_Quantity to 0 on the next edge.
REQ-035 RESET asserted mid-SEARCH or mid-SHIFT SHALL abort the operation with no pulse.

Configuration
REQ-036 The macro BASKET_MERGE_EN SHALL control merging of repeat adds.
REQ-037 With BASKET_MERGE_EN defined, the SEARCH merge behaviour of REQ-018..REQ-020 SHALL apply.
REQ-038 Without BASKET_MERGE_EN, SEARCH SHALL be bypassed and every add SHALL append a new entry (or assert Error_Pulse when full); add latency SHALL then be 1 cycle.

Structure
REQ-039 Package basket_pkg SHALL hold the FSM state encoding, the 4-bit ID/quantity width constants, QTY_MAX=15 and the entry record type {product_id, quantity}.
REQ-040 Entry storage SHALL be a register array inside basket_controller; no sub-module SHALL be used, because SHIFT needs parallel neighbour access.

Verification
REQ-041 Reset, then add ID=3/Q=2 -> BasketProductNum=1, Update_Pulse once; Read_Index=0 gives 3/2.
REQ-042 Add ID=3/Q=14 onto entry 3/2 (MERGE_EN) -> count stays 1, quantity saturates at 15; without MERGE_EN -> count=2.
REQ-043 Fill 8 distinct IDs, then add ID=9 -> Error_Pulse, count=8, contents unchanged.
REQ-044 Basket {1,2,3,4}, cancel index 1 -> after 3 cycles contents {1,3,4}, count=3, Update_Pulse; then cancel index 5 -> Error_Pulse only.
REQ-045 Enable_Pulse and Cancel_Pulse in the same IDLE cycle -> only the cancel executes; a second Enable_Pulse during SEARCH -> Error_Pulse, first add completes.
REQ-046 Assert RESET in the middle of SHIFT -> next cycle count=0, Busy=0, no Update_Pulse.
